// File: rtl/pgm_gfx_rom_cache.sv
// pgm_gfx_rom_cache: direct-mapped line cache between the PGM video engine's
// single-word read port and the MiSTer DDRAM Avalon burst port. A hit answers
// two cycles after accept. A miss fetches the whole line with one burst, then
// answers from the fill data.
module pgm_gfx_rom_cache #(
    parameter int AW    = 29,
    parameter int DW    = 64,
    parameter int BURST = 4,
    parameter int LINES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_rd_i,
    input  logic [AW-1:0] c_addr_i,
    output logic          c_busy_o,
    output logic [DW-1:0] c_dout_o,
    output logic          c_dout_ready_o,
    input  logic          flush_i,
    output logic          ddr_rd_o,
    output logic [AW-1:0] ddr_addr_o,
    output logic [7:0]    ddr_burstcnt_o,
    input  logic          ddr_waitrequest_i,
    input  logic [DW-1:0] ddr_dout_i,
    input  logic          ddr_dout_ready_i
);

    localparam int OFFW  = $clog2(BURST);
    localparam int IDXW  = $clog2(LINES);
    localparam int IDXS  = (IDXW == 0) ? 1 : IDXW;
    localparam int TW    = AW - OFFW - IDXW;
    localparam int WAW   = OFFW + IDXW;
    localparam int WORDS = LINES * BURST;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REQ,
        FILL,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [OFFW-1:0] beat_q, beat_d;
    logic            flush_pend_q, flush_pend_d;
    logic [DW-1:0]   c_dout_q, c_dout_d;
    logic [AW-1:0]   ddr_addr_q, ddr_addr_d;

    logic [DW-1:0]   mem_q [WORDS];
    logic [TW-1:0]   tag_q [LINES];

    logic            mem_we;
    logic            tag_we;
    logic            accept;
    logic            hit;
    logic [OFFW-1:0] off;
    logic [IDXS-1:0] idx;
    logic [TW-1:0]   tag;
    logic [WAW-1:0]  rd_word;
    logic [WAW-1:0]  fill_word;

    // The latched address is split into word offset, line index and tag; with a
    // single line the index collapses to zero.
    assign off       = addr_q[OFFW-1:0];
    assign idx       = addr_q[OFFW +: IDXS] & IDXS'(LINES - 1);
    assign tag       = addr_q[AW-1 -: TW];
    assign rd_word   = WAW'({idx, off});
    assign fill_word = WAW'({idx, beat_q});

    // A flush arriving in the same cycle as the lookup must not be answered
    // from a line that is about to be invalidated.
    assign hit    = valid_q[idx] && (tag_q[idx] == tag) && !flush_i;
    assign accept = c_rd_i && armed_q && (state_q == IDLE);

    assign c_busy_o       = (state_q != IDLE);
    assign c_dout_ready_o = (state_q == RESP);
    assign c_dout_o       = c_dout_q;
    assign ddr_rd_o       = (state_q == REQ);
    assign ddr_addr_o     = ddr_addr_q;
    assign ddr_burstcnt_o = 8'(BURST);

    // Next-state logic: request arming, lookup, burst request, line fill and response.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        c_dout_d     = c_dout_q;
        ddr_addr_d   = ddr_addr_q;
        mem_we       = 1'b0;
        tag_we       = 1'b0;

        if (!c_rd_i) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = c_addr_i;
                    armed_d = 1'b0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    c_dout_d = mem_q[rd_word];
                    state_d  = RESP;
                end else begin
                    ddr_addr_d   = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
                    valid_d[idx] = 1'b0;
                    tag_we       = 1'b1;
                    beat_d       = '0;
                    flush_pend_d = 1'b0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (!ddr_waitrequest_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (ddr_dout_ready_i) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == OFFW'(BURST - 1)) begin
                        c_dout_d     = (off == beat_q) ? ddr_dout_i : mem_q[rd_word];
                        valid_d[idx] = !(flush_pend_q || flush_i);
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            valid_d = '0;
        end
    end

    // Control and output registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            armed_q      <= 1'b1;
            addr_q       <= '0;
            valid_q      <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            c_dout_q     <= '0;
            ddr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            c_dout_q     <= c_dout_d;
            ddr_addr_q   <= ddr_addr_d;
        end
    end

    // Line data and tag storage need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[fill_word] <= ddr_dout_i;
        end
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
    end

endmodule
